handshake_slice_chain: RTL and testbench

// - Parametrised valid/ready register slice: NUM_STAGES identical stages in series, each built in one MODE.
// - Breaks timing on the forward path (valid/data), the backward path (ready), or both, between producer and consumer.
// - Adds a synchronous flush and an occupancy count.
// - Lossless and order-preserving; sits on any streaming point-to-point link.

---
 rtl/handshake_slice_pkg.sv | 26 ++
 rtl/handshake_slice_stage.sv | 116 +++++++++++
 rtl/handshake_slice_chain.sv | 70 +++++++
 tb/tb_handshake_slice_chain.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_slice_pkg.sv
// Shared constants and helpers for the valid/ready register slice chain.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package handshake_slice_pkg;

    localparam int MODE_BYPASS = 0;
    localparam int MODE_FWD    = 1;
    localparam int MODE_BWD    = 2;
    localparam int MODE_FULL   = 3;

    // Words one stage can hold in the given mode.
    function automatic int stage_cap(input int mode);
        case (mode)
            MODE_FWD:  return 1;
            MODE_BWD:  return 1;
            MODE_FULL: return 2;
            default:   return 0;
        endcase
    endfunction

    // Width needed to count up to 2 words per stage across the chain.
    function automatic int occ_width(input int num_stages);
        return $clog2(2 * num_stages + 1);
    endfunction

endpackage

// File: rtl/handshake_slice_stage.sv
// One valid/ready slice stage; MODE selects wires, forward reg, skid, or both.
// Latency: 0 (BYPASS/BWD) or 1 cycle (FWD/FULL).
// Backpressure: BYPASS/FWD pass ready combinationally; BWD/FULL drive ready from a flop.
module handshake_slice_stage
    import handshake_slice_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int MODE       = MODE_FULL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [WORD_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [1:0]            count
);

    logic clear;
    assign clear = rst | flush;

    if (MODE == MODE_FWD) begin : g_fwd
        logic                  v;
        logic [WORD_WIDTH-1:0] d;

        assign in_ready  = !v || out_ready;
        assign out_valid = v;
        assign out_data  = d;
        assign count     = {1'b0, v};

        // Load on every accepted word; drop valid when the word leaves and nothing replaces it.
        always_ff @(posedge clk) begin
            if (clear) begin
                v <= 1'b0;
                d <= '0;
            end else if (in_valid && in_ready) begin
                v <= 1'b1;
                d <= in_data;
            end else if (out_ready) begin
                v <= 1'b0;
            end
        end
    end else if (MODE == MODE_BWD) begin : g_bwd
        logic                  skid_v;
        logic [WORD_WIDTH-1:0] skid_d;

        assign in_ready  = !skid_v;
        assign out_valid = in_valid || skid_v;
        assign out_data  = skid_v ? skid_d : in_data;
        assign count     = {1'b0, skid_v};

        // Catch a word accepted while downstream stalls; release it once downstream takes it.
        always_ff @(posedge clk) begin
            if (clear) begin
                skid_v <= 1'b0;
                skid_d <= '0;
            end else if (skid_v) begin
                if (out_ready) skid_v <= 1'b0;
            end else if (in_valid && !out_ready) begin
                skid_v <= 1'b1;
                skid_d <= in_data;
            end
        end
    end else if (MODE == MODE_FULL) begin : g_full
        logic                  main_v;
        logic [WORD_WIDTH-1:0] main_d;
        logic                  skid_v;
        logic [WORD_WIDTH-1:0] skid_d;
        logic                  in_xfer;
        logic                  main_free;

        assign in_ready  = !skid_v;
        assign out_valid = main_v;
        assign out_data  = main_d;
        assign in_xfer   = in_valid && !skid_v;
        assign main_free = !main_v || out_ready;
        assign count     = {main_v & skid_v, main_v ^ skid_v};

        // Main register feeds downstream; skid absorbs the word accepted while main is stuck.
        // Skid is only ever occupied while main is, so refilling main from skid comes first.
        always_ff @(posedge clk) begin
            if (clear) begin
                main_v <= 1'b0;
                main_d <= '0;
                skid_v <= 1'b0;
                skid_d <= '0;
            end else if (main_free) begin
                if (skid_v) begin
                    main_v <= 1'b1;
                    main_d <= skid_d;
                    skid_v <= 1'b0;
                end else if (in_xfer) begin
                    main_v <= 1'b1;
                    main_d <= in_data;
                end else begin
                    main_v <= 1'b0;
                end
            end else if (in_xfer) begin
                skid_v <= 1'b1;
                skid_d <= in_data;
            end
        end
    end else begin : g_bypass
        logic unused_sink;

        assign in_ready    = out_ready;
        assign out_valid   = in_valid;
        assign out_data    = in_data;
        assign count       = 2'd0;
        assign unused_sink = &{1'b0, clk, clear};
    end

endmodule

// File: rtl/handshake_slice_chain.sv
// Chain of NUM_STAGES valid/ready slices with synchronous flush and occupancy count.
// Latency: 0 (BYPASS/BWD) or NUM_STAGES cycles (FWD/FULL).
// Backpressure: rst/flush force up_ready and down_valid low; otherwise per-stage ready rules.
module handshake_slice_chain
    import handshake_slice_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int NUM_STAGES = 2,
    parameter int MODE       = MODE_FULL
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                up_valid,
    input  logic [WORD_WIDTH-1:0]               up_data,
    output logic                                up_ready,
    output logic                                down_valid,
    output logic [WORD_WIDTH-1:0]               down_data,
    input  logic                                down_ready,
    output logic [occ_width(NUM_STAGES)-1:0]    occupancy
);

    localparam int OCC_W = occ_width(NUM_STAGES);

    // Link i sits in front of stage i; link NUM_STAGES is the consumer side.
    logic [NUM_STAGES:0]                 link_vld;
    logic [NUM_STAGES:0]                 link_rdy;
    logic [NUM_STAGES:0][WORD_WIDTH-1:0] link_dat;
    logic [NUM_STAGES-1:0][1:0]          stage_cnt;
    logic [OCC_W-1:0]                    occ_sum;
    logic                                block;

    // Masking both ends guarantees no transfer completes while clearing.
    assign block                = rst | flush;
    assign link_vld[0]          = up_valid & ~block;
    assign link_dat[0]          = up_data;
    assign up_ready             = link_rdy[0] & ~block;
    assign link_rdy[NUM_STAGES] = down_ready & ~block;
    assign down_valid           = link_vld[NUM_STAGES] & ~block;
    assign down_data            = link_dat[NUM_STAGES];

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        handshake_slice_stage #(
            .WORD_WIDTH (WORD_WIDTH),
            .MODE       (MODE)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (link_vld[i]),
            .in_data   (link_dat[i]),
            .in_ready  (link_rdy[i]),
            .out_valid (link_vld[i+1]),
            .out_data  (link_dat[i+1]),
            .out_ready (link_rdy[i+1]),
            .count     (stage_cnt[i])
        );
    end

    // Occupancy is the sum of per-stage word counts, all derived from stage flops.
    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            occ_sum = occ_sum + OCC_W'(stage_cnt[i]);
        end
    end

    assign occupancy = occ_sum;

endmodule

// File: tb/tb_handshake_slice_chain.sv
module tb_handshake_slice_chain;
    import handshake_slice_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            flush;
    logic [3:0]      uv, ur, dv, dr;
    logic [3:0][7:0] ud, dd;
    logic [3:0][2:0] occ;
    logic [1:0]      occ_n1;

    int checks = 0;
    int errors = 0;

    // Index = mode. The BWD instance is a single stage so one skid decides up_ready.
    handshake_slice_chain #(.WORD_WIDTH(8), .NUM_STAGES(2), .MODE(MODE_BYPASS)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .up_valid(uv[0]), .up_data(ud[0]), .up_ready(ur[0]),
        .down_valid(dv[0]), .down_data(dd[0]), .down_ready(dr[0]), .occupancy(occ[0]));
    handshake_slice_chain #(.WORD_WIDTH(8), .NUM_STAGES(2), .MODE(MODE_FWD)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .up_valid(uv[1]), .up_data(ud[1]), .up_ready(ur[1]),
        .down_valid(dv[1]), .down_data(dd[1]), .down_ready(dr[1]), .occupancy(occ[1]));
    handshake_slice_chain #(.WORD_WIDTH(8), .NUM_STAGES(1), .MODE(MODE_BWD)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .up_valid(uv[2]), .up_data(ud[2]), .up_ready(ur[2]),
        .down_valid(dv[2]), .down_data(dd[2]), .down_ready(dr[2]), .occupancy(occ_n1));
    handshake_slice_chain #(.WORD_WIDTH(8), .NUM_STAGES(2), .MODE(MODE_FULL)) dut3 (
        .clk(clk), .rst(rst), .flush(flush), .up_valid(uv[3]), .up_data(ud[3]), .up_ready(ur[3]),
        .down_valid(dv[3]), .down_data(dd[3]), .down_ready(dr[3]), .occupancy(occ[3]));

    assign occ[2] = {1'b0, occ_n1};

    typedef struct packed {
        logic       rst;
        logic       flush;
        logic       uv;
        logic [7:0] ud;
        logic       dr;
        logic       ur;
        logic       dv;
        logic [7:0] dd;
        logic [2:0] occ;
    } vec_t;

    localparam int NVEC = 22;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic r, input logic f, input logic v, input logic [7:0] d,
                                input logic rd, input logic er, input logic ev,
                                input logic [7:0] ed, input logic [2:0] eo);
        mk = '{r, f, v, d, rd, er, ev, ed, eo};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int  sent [4];
    int  rcvd [4];
    int  cap  [4];
    logic       prev_stall [4];
    logic [7:0] prev_dd    [4];
    logic       xin_r      [4];
    bit  all_done;

    initial begin
        // MODE 3 directed table: reset, fill under backpressure, drain, flush at occupancy 3.
        //            rst   flush uv    ud     dr   | ur    dv    dd     occ
        tbl[0]  = mk(1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
        tbl[1]  = mk(1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
        tbl[2]  = mk(1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
        tbl[3]  = mk(1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
        tbl[4]  = mk(1'b0, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1);
        tbl[5]  = mk(1'b0, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd2);
        tbl[6]  = mk(1'b0, 1'b0, 1'b1, 8'hA4, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd3);
        tbl[7]  = mk(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA1, 3'd4);
        tbl[8]  = mk(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA1, 3'd4);
        tbl[9]  = mk(1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA1, 3'd4);
        tbl[10] = mk(1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA2, 3'd3);
        tbl[11] = mk(1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA3, 3'd2);
        tbl[12] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA4, 3'd2);
        tbl[13] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 3'd1);
        tbl[14] = mk(1'b0, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
        tbl[15] = mk(1'b0, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1);
        tbl[16] = mk(1'b0, 1'b0, 1'b1, 8'hB3, 1'b0, 1'b1, 1'b1, 8'hB1, 3'd2);
        tbl[17] = mk(1'b0, 1'b1, 1'b1, 8'hB4, 1'b1, 1'b0, 1'b0, 8'h00, 3'd3);
        tbl[18] = mk(1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0);
        tbl[19] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd1);
        tbl[20] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 3'd1);
        tbl[21] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0);

        cap[0] = 0; cap[1] = 2; cap[2] = 1; cap[3] = 4;

        rst = 1'b1; flush = 1'b0; uv = '0; ud = '0; dr = '1;
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) begin
            rst   = tbl[i].rst;
            flush = tbl[i].flush;
            uv[3] = tbl[i].uv;
            ud[3] = tbl[i].ud;
            dr[3] = tbl[i].dr;
            @(negedge clk);
            check($sformatf("row%0d up_ready", i),   32'(ur[3]),  32'(tbl[i].ur));
            check($sformatf("row%0d down_valid", i), 32'(dv[3]),  32'(tbl[i].dv));
            check($sformatf("row%0d occupancy", i),  32'(occ[3]), 32'(tbl[i].occ));
            if (tbl[i].dv || tbl[i].rst)
                check($sformatf("row%0d down_data", i), 32'(dd[3]), 32'(tbl[i].dd));
            @(posedge clk); #1;
        end
        rst = 1'b0; flush = 1'b0;

        // MODE 3 streaming 0x01..0x10 back-to-back with the consumer always ready.
        for (int c = 0; c < 18; c++) begin
            uv[3] = (c < 16);
            ud[3] = 8'(c + 1);
            dr[3] = 1'b1;
            @(negedge clk);
            if (c < 16) check($sformatf("stream c%0d up_ready", c), 32'(ur[3]), 32'd1);
            if (c >= 2) begin
                check($sformatf("stream c%0d down_valid", c), 32'(dv[3]), 32'd1);
                check($sformatf("stream c%0d down_data", c),  32'(dd[3]), 32'(c - 1));
                if (c <= 16) check($sformatf("stream c%0d occupancy", c), 32'(occ[3]), 32'd2);
            end
            @(posedge clk); #1;
        end
        uv[3] = 1'b0;

        // MODE 2 single stage: consumer stalls on the cycle 0x3C is accepted.
        uv[2] = 1'b1; ud[2] = 8'h3C; dr[2] = 1'b0;
        @(negedge clk);
        check("skid accept up_ready", 32'(ur[2]), 32'd1);
        check("skid accept down_valid", 32'(dv[2]), 32'd1);
        check("skid accept down_data", 32'(dd[2]), 32'h3C);
        check("skid accept occupancy", 32'(occ[2]), 32'd0);
        @(posedge clk); #1;
        ud[2] = 8'h44;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) dr[2] = 1'b1;
            @(negedge clk);
            check($sformatf("skid hold%0d up_ready", c),   32'(ur[2]),  32'd0);
            check($sformatf("skid hold%0d down_valid", c), 32'(dv[2]),  32'd1);
            check($sformatf("skid hold%0d down_data", c),  32'(dd[2]),  32'h3C);
            check($sformatf("skid hold%0d occupancy", c),  32'(occ[2]), 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("skid drained up_ready", 32'(ur[2]), 32'd1);
        check("skid pass down_data", 32'(dd[2]), 32'h44);
        check("skid drained occupancy", 32'(occ[2]), 32'd0);
        @(posedge clk); #1;
        uv[2] = 1'b0;
        @(negedge clk);
        check("skid idle down_valid", 32'(dv[2]), 32'd0);
        @(posedge clk); #1;

        // All modes: reset with producers asserting valid, then release.
        rst = 1'b1; uv = '1; ud = {4{8'h5A}}; dr = '1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int m = 0; m < 4; m++) begin
                check($sformatf("rst m%0d up_ready", m),   32'(ur[m]),  32'd0);
                check($sformatf("rst m%0d down_valid", m), 32'(dv[m]),  32'd0);
                check($sformatf("rst m%0d occupancy", m),  32'(occ[m]), 32'd0);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0; uv = '0;
        @(negedge clk);
        for (int m = 1; m < 4; m++)
            check($sformatf("release m%0d up_ready", m), 32'(ur[m]), 32'd1);
        @(posedge clk); #1;

        // All modes: random producer, consumer ready toggling every cycle, 200 words each.
        for (int m = 0; m < 4; m++) begin
            sent[m] = 0; rcvd[m] = 0; prev_stall[m] = 1'b0; prev_dd[m] = 8'h00; xin_r[m] = 1'b0;
        end
        all_done = 1'b0;
        for (int cyc = 0; cyc < 4000 && !all_done; cyc++) begin
            @(negedge clk);
            all_done = 1'b1;
            for (int m = 0; m < 4; m++) begin
                if (prev_stall[m])
                    check($sformatf("m%0d stall hold", m), {23'd0, dv[m], dd[m]}, {23'd0, 1'b1, prev_dd[m]});
                if (dv[m] && dr[m]) begin
                    check($sformatf("m%0d word%0d", m, rcvd[m]), 32'(dd[m]), 32'(rcvd[m] % 256));
                    rcvd[m]++;
                end
                xin_r[m] = uv[m] & ur[m];
                if (xin_r[m]) sent[m]++;
                check($sformatf("m%0d occ bound", m), 32'(int'(occ[m]) > cap[m]), 32'd0);
                prev_stall[m] = dv[m] & ~dr[m];
                prev_dd[m]    = dd[m];
                if (rcvd[m] < 200) all_done = 1'b0;
            end
            @(posedge clk); #1;
            dr = ~dr;
            for (int m = 0; m < 4; m++) begin
                if (!uv[m] || xin_r[m]) begin
                    if (sent[m] < 200 && $urandom_range(0, 1) == 1) begin
                        uv[m] = 1'b1;
                        ud[m] = 8'(sent[m]);
                    end else begin
                        uv[m] = 1'b0;
                    end
                end
            end
        end
        for (int m = 0; m < 4; m++)
            check($sformatf("m%0d words delivered", m), 32'(rcvd[m]), 32'd200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
